mul_share_arb: RTL and testbench



---
 rtl/mul_share_arb_if.sv | 28 ++
 rtl/mul_share_arb.sv | 117 +++++++++++
 tb/tb_mul_share_arb.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arb_if.sv
// Handshake bundle for the shared multiplier: per-requester operand ports,
// one product response port and the issue counter.
interface mul_share_arb_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*WIDTH-1:0]    rsp_p;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           issue_cnt;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p, rsp_id, issue_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p, rsp_id, issue_cnt
  );
endinterface

// File: rtl/mul_share_arb.sv
// One signed WIDTH x WIDTH multiplier shared by NREQ requesters through a
// round-robin arbiter; two-stage pipeline stalled by response backpressure.
module mul_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic            CLK,
  input logic            rst_n,
  mul_share_arb_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);

  logic                    r_v1;
  logic signed [WIDTH-1:0] r_a1;
  logic signed [WIDTH-1:0] r_b1;
  logic [ID_W-1:0]         r_id1;
  logic [ID_W-1:0]         r_ptr;
  logic [15:0]             r_cnt;
  logic                    r_rsp_valid;
  logic [2*WIDTH-1:0]      r_rsp_p;
  logic [ID_W-1:0]         r_rsp_id;

  logic                    w_ce;
  logic                    w_found;
  logic                    w_fire;
  logic [ID_W-1:0]         w_gnt;
  logic [NREQ-1:0]         w_req_ready;
  logic [WIDTH-1:0]        w_a;
  logic [WIDTH-1:0]        w_b;
  logic [2*WIDTH-1:0]      w_a_ext;
  logic [2*WIDTH-1:0]      w_b_ext;
  logic [2*WIDTH-1:0]      w_prod;

  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] ptr, input int step);
    int sum;
    sum = int'(ptr) + step;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end else begin
      sum = sum;
    end
    return ID_W'(sum);
  endfunction

  assign w_ce   = !(r_rsp_valid && !bus.rsp_ready);
  assign w_fire = w_found && w_ce;

  // Round-robin search; scanning farthest-first lets the nearest valid requester win.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_gnt   = bus.req_valid[rr_next(r_ptr, k)] ? rr_next(r_ptr, k) : w_gnt;
      w_found = w_found | bus.req_valid[rr_next(r_ptr, k)];
    end
  end

  // One-hot accept for the winner, suppressed while the pipeline is stalled.
  always_comb begin
    w_req_ready = '0;
    if (w_fire) begin
      w_req_ready[w_gnt] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  assign w_a     = bus.req_a[w_gnt*WIDTH +: WIDTH];
  assign w_b     = bus.req_b[w_gnt*WIDTH +: WIDTH];
  assign w_a_ext = {{WIDTH{r_a1[WIDTH-1]}}, r_a1};
  assign w_b_ext = {{WIDTH{r_b1[WIDTH-1]}}, r_b1};
  assign w_prod  = $signed(w_a_ext) * $signed(w_b_ext);

  // Stage 1: operand/ID capture, arbitration pointer and issue counter.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_v1  <= 1'b0;
      r_a1  <= '0;
      r_b1  <= '0;
      r_id1 <= '0;
      r_ptr <= ID_W'(NREQ - 1);
      r_cnt <= 16'd0;
    end else if (w_ce) begin
      if (w_fire) begin
        r_v1  <= 1'b1;
        r_a1  <= w_a;
        r_b1  <= w_b;
        r_id1 <= w_gnt;
        r_ptr <= w_gnt;
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_v1 <= 1'b0;
      end
    end
  end

  // Stage 2: product register; data only refreshed when stage 1 holds an op.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_p     <= '0;
      r_rsp_id    <= '0;
    end else if (w_ce) begin
      r_rsp_valid <= r_v1;
      if (r_v1) begin
        r_rsp_p  <= w_prod;
        r_rsp_id <= r_id1;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_p     = r_rsp_p;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.issue_cnt = r_cnt;
endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a round-robin/pipeline reference model
// and an in-order scoreboard of expected products.
module tb_mul_share_arb;
  logic CLK = 1'b0;
  logic rst_n;

  always #5 CLK = ~CLK;

  mul_share_arb_if #(.NREQ(4), .WIDTH(8)) bus ();

  mul_share_arb #(.NREQ(4), .WIDTH(8)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] p;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [15:0] obs_p[$];
  logic [15:0] last_p;
  logic [1:0]  last_id;
  logic        m_v1;
  logic        m_v2;
  logic [1:0]  m_ptr;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input int a, input int b);
    bus.req_a[i*8 +: 8] = 8'(a);
    bus.req_b[i*8 +: 8] = 8'(b);
  endtask

  task automatic model_reset();
    sb.delete();
    m_v1  = 1'b0;
    m_v2  = 1'b0;
    m_ptr = 2'd3;
    m_cnt = 16'd0;
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    logic              ce;
    logic              found;
    logic [1:0]        g;
    logic [3:0]        er;
    int                idx;
    exp_t              e;
    logic signed [7:0] sa;
    logic signed [7:0] sbv;
    @(negedge CLK);
    ce    = !(m_v2 && !bus.rsp_ready);
    found = 1'b0;
    g     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(m_ptr) + k) % 4;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        g     = idx[1:0];
      end
    end
    er = (found && ce) ? (4'b0001 << g) : 4'b0000;
    check("req_ready", {28'd0, bus.req_ready}, {28'd0, er});
    check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_v2});
    check("issue_cnt", {16'd0, bus.issue_cnt}, {16'd0, m_cnt});
    if (m_v2) begin
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        check("rsp_p", {16'd0, bus.rsp_p}, {16'd0, e.p});
        check("rsp_id", {30'd0, bus.rsp_id}, {30'd0, e.id});
        if (bus.rsp_ready) begin
          last_p  = bus.rsp_p;
          last_id = bus.rsp_id;
          obs_p.push_back(bus.rsp_p);
          void'(sb.pop_front());
        end
      end
    end
    if (ce) begin
      m_v2 = m_v1;
      m_v1 = found;
      if (found) begin
        sa   = bus.req_a[g*8 +: 8];
        sbv  = bus.req_b[g*8 +: 8];
        e.id = g;
        e.p  = 16'(16'(sa) * 16'(sbv));
        sb.push_back(e);
        m_ptr = g;
        m_cnt = m_cnt + 16'd1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 4'b0000;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    model_reset();

    // Reset state
    #2;
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_p", {16'd0, bus.rsp_p}, 32'd0);
    check("rst_rsp_id", {30'd0, bus.rsp_id}, 32'd0);
    check("rst_issue_cnt", {16'd0, bus.issue_cnt}, 32'd0);
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;

    // All requesters contend: grants 0,1,2,3,0,...
    bus.req_valid = 4'b1111;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 4; i++) set_op(i, j*16 + i*3 - 40, 5 - i*7 + j);
      cycle();
    end
    idle(3);
    check("t2_drained", sb.size(), 32'd0);

    // Single op from requester 2: 3 * -4
    obs_p.delete();
    bus.req_valid = 4'b0100;
    set_op(2, 3, -4);
    cycle();
    idle(3);
    check("t1_count", obs_p.size(), 32'd1);
    check("t1_p", {16'd0, last_p}, 32'h0000_FFF4);
    check("t1_id", {30'd0, last_id}, 32'd2);

    // Two contenders alternate
    bus.req_valid = 4'b0101;
    for (int j = 0; j < 6; j++) begin
      set_op(0, j + 1, -j - 2);
      set_op(2, 2*j - 9, j + 11);
      cycle();
    end
    idle(3);

    // Backpressure on a stream from requester 1
    bus.req_valid = 4'b0010;
    for (int j = 0; j < 4; j++) begin
      set_op(1, 17*j - 30, 9 - 5*j);
      cycle();
    end
    bus.rsp_ready = 1'b0;
    for (int j = 0; j < 3; j++) cycle();
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      set_op(1, 40 + j, -3 - j);
      cycle();
    end
    idle(4);
    check("t4_drained", sb.size(), 32'd0);

    // Operand extremes from requester 3
    obs_p.delete();
    bus.req_valid = 4'b1000;
    set_op(3, -128, -128); cycle();
    set_op(3, -128, 127);  cycle();
    set_op(3, 127, 127);   cycle();
    set_op(3, 0, -1);      cycle();
    idle(3);
    check("t5_count", obs_p.size(), 32'd4);
    if (obs_p.size() == 4) begin
      check("t5_m128_m128", {16'd0, obs_p[0]}, 32'h0000_4000);
      check("t5_m128_127", {16'd0, obs_p[1]}, 32'h0000_C080);
      check("t5_127_127", {16'd0, obs_p[2]}, 32'h0000_3F01);
      check("t5_0_m1", {16'd0, obs_p[3]}, 32'h0000_0000);
    end

    // Asynchronous reset with two ops in flight
    bus.req_valid = 4'b0011;
    set_op(0, 5, 6);
    set_op(1, -7, 8);
    cycle();
    cycle();
    bus.req_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("t6_issue_cnt", {16'd0, bus.issue_cnt}, 32'd0);
    model_reset();
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_op(i, i + 2, 3 - i);
    cycle();
    idle(4);
    check("final_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
